// File: rtl/user_led_drv_pkg.sv
// Shared types, constants and the level-to-duty mapping for the user LED fade driver.
// Optional build macro: USER_LED_GAMMA_EN selects a quadratic brightness curve instead of linear.
package user_led_drv_pkg;

  localparam int PWM_W = 8;
  localparam logic [PWM_W-1:0] LEVEL_MAX = 8'd255;

  typedef enum logic [1:0] {
    OFF  = 2'd0,
    RISE = 2'd1,
    ON   = 2'd2,
    FALL = 2'd3
  } led_state_e;

  // The gamma curve is level*(level+1)/256, which maps 255 exactly onto full scale.
  function automatic logic [PWM_W-1:0] duty_of(input logic [PWM_W-1:0] level);
`ifdef USER_LED_GAMMA_EN
    logic [2*PWM_W-1:0] prod;
    prod = {{PWM_W{1'b0}}, level} * ({{PWM_W{1'b0}}, level} + 16'd1);
    return prod[2*PWM_W-1:PWM_W];
`else
    return level;
`endif
  endfunction

endpackage

// File: rtl/user_led_fade_channel.sv
// One LED channel: on/off/fade FSM, brightness level, per-period duty latch and PWM compare.
// Brightness curve follows USER_LED_GAMMA_EN through the package duty function.
module user_led_fade_channel
  import user_led_drv_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req,
  input  logic             step,
  input  logic             period_end,
  input  logic [PWM_W-1:0] pwm_cnt,
  output logic             led_out,
  output logic             busy
);

  led_state_e       state_q, state_d;
  logic [PWM_W-1:0] level_q, level_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             led_q, led_d;
  logic             busy_q, busy_d;
  logic             on_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= OFF;
      level_q <= '0;
      duty_q  <= '0;
      led_q   <= ACTIVE_LOW;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      duty_q  <= duty_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    duty_d  = duty_q;
    busy_d  = 1'b0;
    on_w    = 1'b0;
    led_d   = ACTIVE_LOW;

    // Direction is decided by req first so a coincident step moves the new way.
    case (state_q)
      OFF:     if (req)  state_d = RISE;
      RISE:    if (!req) state_d = FALL;
      ON:      if (!req) state_d = FALL;
      FALL:    if (req)  state_d = RISE;
      default: state_d = OFF;
    endcase

    if (step) begin
      if (state_d == RISE && level_q != LEVEL_MAX) begin
        level_d = level_q + 8'd1;
      end else if (state_d == FALL && level_q != '0) begin
        level_d = level_q - 8'd1;
      end
    end

    if (state_d == RISE && level_d == LEVEL_MAX) begin
      state_d = ON;
    end else if (state_d == FALL && level_d == '0) begin
      state_d = OFF;
    end

    // Duty only changes at a period boundary so a period never shows two widths.
    if (period_end) begin
      duty_d = duty_of(level_d);
    end

    busy_d = (state_d == RISE) || (state_d == FALL);
    on_w   = (duty_q == LEVEL_MAX) || (pwm_cnt < duty_q);
    led_d  = on_w ^ ACTIVE_LOW;
  end

  assign led_out = led_q;
  assign busy    = busy_q;

endmodule

// File: rtl/user_led_fade_driver.sv
// User LED fade driver: shared PWM timebase feeding one fade channel per PIO LED bit.
// Define USER_LED_GAMMA_EN for a gamma-corrected brightness curve; linear otherwise.
module user_led_fade_driver
  import user_led_drv_pkg::*;
#(
  parameter int NUM_LEDS          = 4,
  parameter int PRESCALE_DIV      = 49,
  parameter int FADE_STEP_PERIODS = 4,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_LEDS-1:0] led_req,
  output logic [NUM_LEDS-1:0] led_out,
  output logic [NUM_LEDS-1:0] led_busy
);

  localparam int PRE_W  = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
  localparam int FADE_W = (FADE_STEP_PERIODS > 1) ? $clog2(FADE_STEP_PERIODS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PRESCALE_DIV - 1);
  localparam logic [FADE_W-1:0] FADE_LAST = FADE_W'(FADE_STEP_PERIODS - 1);

  logic [PRE_W-1:0]  presc_q, presc_d;
  logic [PWM_W-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [FADE_W-1:0] fade_q, fade_d;
  logic              tick, period_end, step;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      fade_q    <= '0;
    end else begin
      presc_q   <= presc_d;
      pwm_cnt_q <= pwm_cnt_d;
      fade_q    <= fade_d;
    end
  end

  always_comb begin
    tick       = (presc_q == PRE_LAST);
    period_end = tick && (pwm_cnt_q == LEVEL_MAX);
    step       = period_end && (fade_q == FADE_LAST);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    pwm_cnt_d  = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    fade_d     = fade_q;
    if (period_end) begin
      fade_d = (fade_q == FADE_LAST) ? '0 : fade_q + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_ch
    user_led_fade_channel #(
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_ch (
      .clk        (clk),
      .reset_n    (reset_n),
      .req        (led_req[i]),
      .step       (step),
      .period_end (period_end),
      .pwm_cnt    (pwm_cnt_q),
      .led_out    (led_out[i]),
      .busy       (led_busy[i])
    );
  end

endmodule

// File: tb/tb_user_led_fade_driver.sv
// Bench for user_led_fade_driver: three instances (active-high, active-low, mid-run reset)
// checked every cycle against a level-chases-target reference model.
module tb_user_led_fade_driver;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       reset_rr_n;
  logic [3:0] led_req;
  logic [3:0] out_a, busy_a, out_b, busy_b, out_c, busy_c;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model, context 0 = main reset, context 1 = separately reset instance.
  int         m_level[2][4];
  int         m_duty[2][4];
  int         m_pwm[2];
  logic [3:0] m_out[2];
  logic [3:0] m_busy[2];

  int    win_left = 0;
  int    win_cnt  = 0;
  int    win_exp  = 0;
  bit    win_arm  = 1'b0;
  bit    win_is_full = 1'b0;
  bit    win_cur_full = 1'b0;
  bit    full_win_done = 1'b0;
  bit    mid_win_done = 1'b0;
  string win_tag;

  always #5 clk = ~clk;

  user_led_fade_driver #(.NUM_LEDS(4), .PRESCALE_DIV(1), .FADE_STEP_PERIODS(1), .ACTIVE_LOW(1'b0)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .led_req(led_req), .led_out(out_a), .led_busy(busy_a));

  user_led_fade_driver #(.NUM_LEDS(4), .PRESCALE_DIV(1), .FADE_STEP_PERIODS(1), .ACTIVE_LOW(1'b1)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .led_req(led_req), .led_out(out_b), .led_busy(busy_b));

  user_led_fade_driver #(.NUM_LEDS(4), .PRESCALE_DIV(1), .FADE_STEP_PERIODS(1), .ACTIVE_LOW(1'b0)) u_dut_c (
    .clk(clk), .reset_n(reset_rr_n), .led_req(led_req), .led_out(out_c), .led_busy(busy_c));

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int duty_ref(input int lvl);
`ifdef USER_LED_GAMMA_EN
    return (lvl * (lvl + 1)) / 256;
`else
    return lvl;
`endif
  endfunction

  task automatic model_reset(input int c);
    for (int ch = 0; ch < 4; ch++) begin
      m_level[c][ch] = 0;
      m_duty[c][ch]  = 0;
    end
    m_pwm[c]  = 0;
    m_out[c]  = 4'h0;
    m_busy[c] = 4'h0;
  endtask

  // Brightness walks one level per PWM period toward 0 or 255 as the request dictates.
  task automatic model_edge(input int c);
    bit pe;
    int tgt;
    pe = (m_pwm[c] == 255);
    for (int ch = 0; ch < 4; ch++) begin
      m_out[c][ch] = (m_duty[c][ch] == 255) || (m_pwm[c] < m_duty[c][ch]);
      tgt = led_req[ch] ? 255 : 0;
      if (pe) begin
        if (m_level[c][ch] != tgt) begin
          m_level[c][ch] += (m_level[c][ch] < tgt) ? 1 : -1;
          if (c == 0 && ch == 0 && (m_level[c][ch] == 64 || m_level[c][ch] == 255)) begin
            win_arm     = 1'b1;
            win_is_full = (m_level[c][ch] == 255);
          end
        end
        m_duty[c][ch] = duty_ref(m_level[c][ch]);
      end
      m_busy[c][ch] = (m_level[c][ch] != tgt);
    end
    m_pwm[c] = (m_pwm[c] + 1) % 256;
  endtask

  task automatic compare_all();
    check_eq("out_a", {28'd0, out_a}, {28'd0, m_out[0]});
    check_eq("busy_a", {28'd0, busy_a}, {28'd0, m_busy[0]});
    check_eq("out_b", {28'd0, out_b}, {28'd0, ~m_out[0]});
    check_eq("busy_b", {28'd0, busy_b}, {28'd0, m_busy[0]});
    check_eq("out_c", {28'd0, out_c}, {28'd0, m_out[1]});
    check_eq("busy_c", {28'd0, busy_c}, {28'd0, m_busy[1]});
  endtask

  // Counts ch0 high cycles over the full period that follows a level of interest.
  task automatic window_update();
    if (win_left > 0) begin
      win_cnt += int'(out_a[0]);
      win_left--;
      if (win_left == 0) begin
        check_eq(win_tag, win_cnt, win_exp);
        if (win_cur_full) full_win_done = 1'b1;
        else mid_win_done = 1'b1;
      end
    end
    if (win_arm) begin
      win_arm      = 1'b0;
      win_left     = 256;
      win_cnt      = 0;
      win_cur_full = win_is_full;
      win_exp      = win_is_full ? 256 : m_duty[0][0];
      win_tag      = win_is_full ? "hi_cycles_lvl255" : "hi_cycles_lvl64";
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    if (reset_n) model_edge(0);
    if (reset_rr_n) model_edge(1);
    #1;
    compare_all();
    window_update();
  endtask

  initial begin
    bit ch1_dropped = 1'b0;
    bit rr_done     = 1'b0;
    bit pulse_back  = 1'b0;
    bit done        = 1'b0;
    int rr_hold     = 0;
    int cyc         = 0;
    int r;

    led_req    = 4'h0;
    reset_n    = 1'b0;
    reset_rr_n = 1'b0;
    model_reset(0);
    model_reset(1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_a", {28'd0, out_a}, 32'h0);
    check_eq("rst_busy_a", {28'd0, busy_a}, 32'h0);
    check_eq("rst_out_b", {28'd0, out_b}, 32'hF);
    @(negedge clk);
    reset_n    = 1'b1;
    reset_rr_n = 1'b1;

    repeat (1000) run_cycle();

    led_req = 4'b0001;
    run_cycle();
    check_eq("busy_first", {28'd0, busy_a}, 32'h1);
    led_req = 4'b0111;

    while (!done && cyc < 70000) begin
      run_cycle();
      cyc++;
      if (!ch1_dropped && m_level[0][1] == 100) begin
        led_req[1]  = 1'b0;
        ch1_dropped = 1'b1;
      end
      if (pulse_back) begin
        led_req[3] = ~led_req[3];
        pulse_back = 1'b0;
      end else begin
        r = $urandom_range(0, 2999);
        if (r < 2) begin
          led_req[3] = ~led_req[3];
          pulse_back = (r == 1);
        end
      end
      if (rr_hold > 0) begin
        rr_hold--;
        if (rr_hold == 0) begin
          #2 reset_rr_n = 1'b1;
        end
      end
      if (!rr_done && m_level[1][2] == 128) begin
        #1 reset_rr_n = 1'b0;
        #1;
        check_eq("rr_async_out", {28'd0, out_c}, 32'h0);
        check_eq("rr_async_busy", {28'd0, busy_c}, 32'h0);
        model_reset(1);
        rr_hold = 3;
        rr_done = 1'b1;
      end
      done = full_win_done && ch1_dropped && (m_level[0][1] == 0) && (m_busy[0][1] == 1'b0);
    end

    check_eq("run_bound", {31'd0, done}, 32'd1);
    check_eq("mid_window_seen", {31'd0, mid_win_done}, 32'd1);
    check_eq("rr_reset_seen", {31'd0, rr_done}, 32'd1);
    check_eq("ch0_busy_end", {31'd0, busy_a[0]}, 32'd0);
    check_eq("ch1_busy_end", {31'd0, busy_a[1]}, 32'd0);
    check_eq("ch1_out_end", {31'd0, out_a[1]}, 32'd0);
    check_eq("ch0_out_end_al", {31'd0, out_b[0]}, 32'd0);
    check_eq("rr_ch2_restart_busy", {31'd0, busy_c[2]}, 32'd1);
    repeat (300) run_cycle();
    check_eq("ch1_out_idle", {31'd0, out_a[1]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
